// File: rtl/ats21_cmd_issuer.sv
// rtl/ats21_cmd_issuer.sv - ATS21 two-word command issuer with Nack retry and alarm edge capture
// Optional saturating ACK/NACK counters are built when ATS21_ISSUER_STATS_EN is defined.
module ats21_cmd_issuer #(
  parameter int CLIENT_SEL = 0,
  parameter int RSP_LAT    = 1,
  parameter int MAX_RETRY  = 3,
  parameter int NUM_ALARMS = 24
) (
  input  logic                  clk_1x,
  input  logic                  reset,
  input  logic                  cmd_valid,
  input  logic [31:0]           cmd_data,
  output logic                  cmd_ready,
  output logic                  rsp_valid,
  output logic [1:0]            rsp_status,
  output logic                  req,
  output logic [15:0]           ctrl,
  input  logic [1:0]            stat,
  input  logic [NUM_ALARMS-1:0] alarm_data,
  output logic [NUM_ALARMS-1:0] alarm_pending,
  input  logic [NUM_ALARMS-1:0] alarm_clr,
  output logic [15:0]           ack_cnt,
  output logic [15:0]           nack_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_NOP, S_HI, S_LO, S_WAIT, S_GAP, S_DONE
  } state_t;

  localparam logic [1:0] ST_ACK    = 2'b00;
  localparam logic [1:0] ST_NACK   = 2'b01;
  localparam logic [1:0] ST_NORESP = 2'b10;
  localparam logic [1:0] ST_NOP    = 2'b11;

  state_t      state, state_nxt;
  logic [31:0] cmd_q;
  logic [3:0]  wait_cnt;
  logic [3:0]  retry_cnt;
  logic [1:0]  status_q, status_nxt;
  logic        stat_bit;
  logic        no_status;
  logic        sample_pt;
  logic        nack_ev;
  logic        do_retry;

  assign stat_bit  = stat[CLIENT_SEL];
  // Opcodes 011 and 111 never update stat, so the sample is skipped.
  assign no_status = (cmd_q[30:29] == 2'b11);
  assign sample_pt = (state == S_WAIT) && (wait_cnt == 4'd1);
  assign nack_ev   = sample_pt && !no_status && !stat_bit;
  assign do_retry  = nack_ev && (retry_cnt < 4'(MAX_RETRY));

  always_ff @(posedge clk_1x or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    status_nxt = status_q;
    cmd_ready  = 1'b0;
    req        = 1'b0;
    ctrl       = 16'h0000;
    rsp_valid  = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          state_nxt = (cmd_data[31:29] == 3'b000) ? S_NOP : S_HI;
        end
      end
      S_NOP: begin
        status_nxt = ST_NOP;
        state_nxt  = S_DONE;
      end
      S_HI: begin
        req       = 1'b1;
        ctrl      = cmd_q[31:16];
        state_nxt = S_LO;
      end
      S_LO: begin
        req       = 1'b1;
        ctrl      = cmd_q[15:0];
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (sample_pt) begin
          if (no_status) begin
            status_nxt = ST_NORESP;
            state_nxt  = S_DONE;
          end else if (stat_bit) begin
            status_nxt = ST_ACK;
            state_nxt  = S_DONE;
          end else if (do_retry) begin
            state_nxt = S_GAP;
          end else begin
            status_nxt = ST_NACK;
            state_nxt  = S_DONE;
          end
        end
      end
      S_GAP: begin
        state_nxt = S_HI;
      end
      S_DONE: begin
        rsp_valid = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_1x or posedge reset) begin
    if (reset) begin
      cmd_q     <= 32'h0;
      wait_cnt  <= 4'd0;
      retry_cnt <= 4'd0;
      status_q  <= ST_ACK;
    end else begin
      status_q <= status_nxt;
      if (state == S_IDLE && cmd_valid) begin
        cmd_q <= cmd_data;
      end
      if (state == S_LO) begin
        wait_cnt <= 4'(RSP_LAT);
      end else if (state == S_WAIT && wait_cnt != 4'd1) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (state == S_DONE) begin
        retry_cnt <= 4'd0;
      end else if (do_retry) begin
        retry_cnt <= retry_cnt + 4'd1;
      end
    end
  end

  assign rsp_status = status_q;

  // Alarm capture runs every cycle, independent of the command FSM.
  logic [NUM_ALARMS-1:0] alarm_q;
  logic [NUM_ALARMS-1:0] pending_q;

  always_ff @(posedge clk_1x or posedge reset) begin
    if (reset) begin
      alarm_q   <= '0;
      pending_q <= '0;
    end else begin
      alarm_q   <= alarm_data;
      pending_q <= (pending_q & ~alarm_clr) | (alarm_data & ~alarm_q);
    end
  end

  assign alarm_pending = pending_q;

`ifdef ATS21_ISSUER_STATS_EN
  logic        ack_ev;
  logic [15:0] ack_q;
  logic [15:0] nack_q;

  assign ack_ev = sample_pt && !no_status && stat_bit;

  always_ff @(posedge clk_1x or posedge reset) begin
    if (reset) begin
      ack_q  <= 16'h0000;
      nack_q <= 16'h0000;
    end else begin
      if (ack_ev && ack_q != 16'hFFFF) begin
        ack_q <= ack_q + 16'd1;
      end
      if (nack_ev && nack_q != 16'hFFFF) begin
        nack_q <= nack_q + 16'd1;
      end
    end
  end

  assign ack_cnt  = ack_q;
  assign nack_cnt = nack_q;
`else
  assign ack_cnt  = 16'h0000;
  assign nack_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_ats21_cmd_issuer.sv
// tb/tb_ats21_cmd_issuer.sv - randomized self-checking bench for ats21_cmd_issuer
module tb_ats21_cmd_issuer;

  localparam int RSP_LAT   = 1;
  localparam int MAX_RETRY = 3;
  localparam int NA        = 24;

  logic          clk_1x = 1'b0;
  logic          reset  = 1'b1;
  logic          cmd_valid = 1'b0;
  logic [31:0]   cmd_data  = 32'h0;
  logic          cmd_ready;
  logic          rsp_valid;
  logic [1:0]    rsp_status;
  logic          req;
  logic [15:0]   ctrl;
  logic [1:0]    stat = 2'b00;
  logic [NA-1:0] alarm_data = '0;
  logic [NA-1:0] alarm_pending;
  logic [NA-1:0] alarm_clr = '0;
  logic [15:0]   ack_cnt;
  logic [15:0]   nack_cnt;

  ats21_cmd_issuer #(
    .CLIENT_SEL(0), .RSP_LAT(RSP_LAT), .MAX_RETRY(MAX_RETRY), .NUM_ALARMS(NA)
  ) dut (
    .clk_1x(clk_1x), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
    .rsp_valid(rsp_valid), .rsp_status(rsp_status),
    .req(req), .ctrl(ctrl), .stat(stat),
    .alarm_data(alarm_data), .alarm_pending(alarm_pending), .alarm_clr(alarm_clr),
    .ack_cnt(ack_cnt), .nack_cnt(nack_cnt)
  );

  always #5 clk_1x = ~clk_1x;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_ack  = 0;
  int exp_nack = 0;
  logic [NA-1:0] prev_m = '0;
  logic [NA-1:0] pend_m = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_counters(input string tag);
`ifdef ATS21_ISSUER_STATS_EN
    check({tag, "_ack_cnt"}, 32'(ack_cnt), 32'(exp_ack));
    check({tag, "_nack_cnt"}, 32'(nack_cnt), 32'(exp_nack));
`else
    check({tag, "_ack_cnt"}, 32'(ack_cnt), 32'd0);
    check({tag, "_nack_cnt"}, 32'(nack_cnt), 32'd0);
`endif
  endtask

  // Issue one command; plan[k] is the stat[0] value returned for issue k.
  task automatic run_cmd(input string tag, input logic [31:0] data, input logic [15:0] plan);
    int waited = 0;
    int req_cyc = 0, run = 0, max_run = 0, ctrl_err = 0;
    int attempts, exp_lat, lat = 0;
    logic [1:0] exp_st;
    logic [1:0] got_st = 2'b00;
    logic got_rsp = 1'b0;
    logic [15:0] exp_ctrl;

    if (data[31:29] == 3'b000) begin
      attempts = 0;
      exp_st   = 2'b11;
      exp_lat  = 2;
    end else if (data[30:29] == 2'b11) begin
      attempts = 1;
      exp_st   = 2'b10;
      exp_lat  = 3 + RSP_LAT;
    end else begin
      attempts = 0;
      exp_st   = 2'b01;
      for (int k = 0; k <= MAX_RETRY; k++) begin
        attempts++;
        if (plan[k]) begin
          exp_st = 2'b00;
          break;
        end
      end
      exp_lat = attempts * (3 + RSP_LAT);
      if (exp_st == 2'b00) begin
        exp_ack++;
        exp_nack += attempts - 1;
      end else begin
        exp_nack += attempts;
      end
    end

    while (!cmd_ready && waited < 50) begin
      @(negedge clk_1x);
      waited++;
    end
    check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_data  = data;
    @(negedge clk_1x);
    cmd_valid = 1'b0;
    cmd_data  = $urandom;
    check({tag, "_busy"}, 32'(cmd_ready), 32'd0);

    for (int n = 1; n <= 100; n++) begin
      if (req) begin
        exp_ctrl = (req_cyc % 2 == 0) ? data[31:16] : data[15:0];
        if (ctrl !== exp_ctrl) ctrl_err++;
        req_cyc++;
        run++;
        if (run > max_run) max_run = run;
      end else begin
        if (ctrl !== 16'h0000) ctrl_err++;
        run = 0;
      end
      if (rsp_valid) begin
        got_rsp = 1'b1;
        got_st  = rsp_status;
        lat     = n;
        break;
      end
      stat[1] = 1'($urandom);
      if (!req && req_cyc > 0 && req_cyc % 2 == 0)
        stat[0] = plan[req_cyc/2 - 1];
      else
        stat[0] = 1'($urandom);
      @(negedge clk_1x);
    end

    check({tag, "_rsp_seen"}, 32'(got_rsp), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_status"}, 32'(got_st), 32'(exp_st));
    check({tag, "_req_cycles"}, 32'(req_cyc), 32'(2 * attempts));
    check({tag, "_req_run_le2"}, 32'(max_run <= 2), 32'd1);
    check({tag, "_ctrl_errs"}, 32'(ctrl_err), 32'd0);
    @(negedge clk_1x);
    check({tag, "_rsp_one_cycle"}, 32'(rsp_valid), 32'd0);
    check({tag, "_status_held"}, 32'(rsp_status), 32'(exp_st));
    check_counters(tag);
  endtask

  task automatic alarm_step(input string tag, input logic [NA-1:0] d, input logic [NA-1:0] c);
    alarm_data = d;
    alarm_clr  = c;
    pend_m = (pend_m & ~c) | (d & ~prev_m);
    prev_m = d;
    @(negedge clk_1x);
    alarm_clr = '0;
    check(tag, 32'(alarm_pending), 32'(pend_m));
  endtask

  initial begin
    repeat (2) @(negedge clk_1x);
    check("rst_req", 32'(req), 32'd0);
    check("rst_ctrl", 32'(ctrl), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_status", 32'(rsp_status), 32'd0);
    check("rst_pending", 32'(alarm_pending), 32'd0);
    check_counters("rst");
    reset = 1'b0;
    @(negedge clk_1x);

    run_cmd("ack_first", 32'h2A40_1234, 16'hFFFF);
    run_cmd("ack_third", 32'hA300_0050, 16'b0100);
    run_cmd("nack_all", 32'h2000_0001, 16'h0000);
    run_cmd("nop", 32'h0000_0000, 16'hFFFF);
    run_cmd("noresp3", 32'h7000_0000, 16'h0000);
    run_cmd("noresp7", 32'hE123_4567, 16'hFFFF);
    for (int i = 0; i < 24; i++) begin
      logic [31:0] d;
      d = $urandom;
      if (i % 6 == 0) d[31:29] = 3'b000;
      run_cmd("rand_cmd", d, 16'($urandom));
    end

    alarm_step("al5_rise", NA'(1) << 5, '0);
    check("al5_set", 32'(alarm_pending[5]), 32'd1);
    alarm_step("al5_hold", NA'(1) << 5, '0);
    alarm_step("al5_low", '0, '0);
    alarm_step("al5_clr", '0, NA'(1) << 5);
    check("al5_cleared", 32'(alarm_pending[5]), 32'd0);
    alarm_step("al5_set_wins", NA'(1) << 5, NA'(1) << 5);
    check("al5_set_over_clr", 32'(alarm_pending[5]), 32'd1);
    for (int i = 0; i < 60; i++) begin
      alarm_step("al_rand", NA'($urandom), NA'($urandom & $urandom & $urandom));
    end

    // Reset during WAIT: abort without response, clear pending, then resume.
    alarm_step("al_pre_rst", NA'(24'h000101), '0);
    cmd_valid = 1'b1;
    cmd_data  = 32'h2A40_1234;
    @(negedge clk_1x);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk_1x);
    reset = 1'b1;
    alarm_data = '0;
    #1;
    check("midrst_req", 32'(req), 32'd0);
    check("midrst_ready", 32'(cmd_ready), 32'd1);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_pending", 32'(alarm_pending), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_1x);
      check("midrst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    reset = 1'b0;
    prev_m = '0;
    pend_m = '0;
    exp_ack = 0;
    exp_nack = 0;
    @(negedge clk_1x);
    check("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
    run_cmd("post_rst", 32'h2A40_1234, 16'b0010);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ats21_cmd_issuer.md
Name: ats21_cmd_issuer

Overview:
- Client-side initiator for the ATS21 two-word instruction interface; drives one client port (ctrlA or ctrlB) plus req.
- Accepts 32-bit commands from a host over valid/ready, serialises each into two 16-bit halves, samples the ATS21 stat bit and retries on Nack.
- Captures rising edges of the ATS21 alarm data bus into sticky, host-clearable pending flags.

Parameters:
- CLIENT_SEL, 0, selects the response bit: 0 = stat[0] (client A), 1 = stat[1] (client B).
- RSP_LAT, 1, cycles from the low-half cycle to the stat sample point (1..15).
- MAX_RETRY, 3, re-issues after a Nack before reporting failure (0..15).
- NUM_ALARMS, 24, width of the alarm data bus.

Ports:
- clk_1x  in  1  ATS21 reference clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high.
- cmd_valid  in  1  host command valid.
- cmd_data  in  32  command; opcode is [31:29].
- cmd_ready  out  1  high only in IDLE.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_status  out  2  00 ACK, 01 NACK (retries exhausted), 10 NORESP, 11 NOP.
- req  out  1  ATS21 request.
- ctrl  out  16  ATS21 ctrl half-word.
- stat  in  2  ATS21 status, {B, A}.
- alarm_data  in  NUM_ALARMS  ATS21 data bus, one finished bit per alarm.
- alarm_pending  out  NUM_ALARMS  sticky rising-edge flags.
- alarm_clr  in  NUM_ALARMS  write-1-to-clear mask, one cycle.
- ack_cnt  out  16  see Optional Feature.
- nack_cnt  out  16  see Optional Feature.

Behaviour:
Reset:
- req=0, ctrl=0, cmd_ready=1, rsp_valid=0, rsp_status=00.
- alarm_pending=0, retry count=0, edge-detect register=0, state IDLE.
- Reset asserted mid-command aborts it; no response is issued.

Command acceptance:
- A handshake occurs when cmd_valid && cmd_ready. cmd_data is registered internally.
- Opcode 000: no bus activity; next cycle goes to DONE with status NOP.
- Any other opcode: go to HI.

State machine:
- IDLE: cmd_ready=1, req=0, ctrl=0.
- HI: req=1, ctrl=cmd[31:16]; next state LO.
- LO: req=1, ctrl=cmd[15:0]; next state WAIT, wait counter loaded with RSP_LAT.
- WAIT: req=0, ctrl=0. Counter decrements; on the cycle it reads 1, stat[CLIENT_SEL] is sampled and the next state is chosen:
  - Opcode 011 or 111 (ATS21 does not update status): DONE, status NORESP, no sampling.
  - Sampled 1: DONE, status ACK.
  - Sampled 0 and retries < MAX_RETRY: retries++, go to GAP.
  - Sampled 0 and retries == MAX_RETRY: DONE, status NACK.
- GAP: one idle cycle with req=0 so ATS21 resynchronises its half-word counter; next state HI.
- DONE: rsp_valid=1 for exactly one cycle, rsp_status held until the next DONE; retries cleared; next state IDLE.

Timing:
- Latency from accept to rsp_valid is 3+RSP_LAT cycles with no retries.
- Each retry adds 3+RSP_LAT cycles.
- A NOP takes 2 cycles.
- Back-to-back commands: the earliest next accept is the cycle after DONE.

Alarm capture:
- alarm_data is registered every cycle. pending[i] is set when data[i] is 1 and was 0 in the previous cycle.
- An alarm that stays high (2-cycle pulse) sets its flag once.
- alarm_clr[i] clears pending[i]. If set and clear occur in the same cycle, set wins.
- Capture operates independently of the command FSM.

Optional Feature:
- Macro: ATS21_ISSUER_STATS_EN.
- Defined: ack_cnt increments on each DONE with ACK; nack_cnt increments on every sampled Nack, including retried ones. Both are 16-bit, saturate at 0xFFFF and reset to 0.
- Undefined: ack_cnt and nack_cnt are tied to 0 and no counter logic is built.

Test Plan:
- Accept 0x2A40_1234, stat[0] held 1 -> HI drives ctrl=0x2A40, LO drives ctrl=0x1234, req=1 for exactly 2 cycles, rsp_valid 4 cycles after accept with status 00.
- Accept 0xA300_0050, stat[0]=0 for the first two samples then 1 -> two GAP+reissue sequences, final status ACK; with the macro, nack_cnt=2 and ack_cnt=1.
- stat[0] held 0, MAX_RETRY=3 -> 4 issues total, status 01, req never asserted more than 2 consecutive cycles.
- Accept 0x0000_0000 -> req stays 0, rsp_valid 2 cycles after accept, status 11; accept 0x7000_0000 -> bus issued, status 10 regardless of stat.
- alarm_data[5] high for 2 cycles -> pending[5]=1 once; alarm_clr[5] asserted on the same cycle as a new rising edge of data[5] -> pending[5] remains 1.
- Reset asserted during WAIT -> req=0, state IDLE, no rsp_valid, pending cleared; the next command completes normally.
